// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, strobe indices,
// FSM state encoding and the operand-fetch decode helper.
package alu_pkg;

  localparam int unsigned OPC_W  = 5;
  localparam int unsigned CTRL_W = 14;

  localparam logic [OPC_W-1:0] OP_ADD = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 5'd1;
  localparam logic [OPC_W-1:0] OP_MUL = 5'd2;
  localparam logic [OPC_W-1:0] OP_DIV = 5'd3;
  localparam logic [OPC_W-1:0] OP_AND = 5'd4;
  localparam logic [OPC_W-1:0] OP_OR  = 5'd5;
  localparam logic [OPC_W-1:0] OP_XOR = 5'd6;
  localparam logic [OPC_W-1:0] OP_NOT = 5'd7;
  localparam logic [OPC_W-1:0] OP_INC = 5'd8;
  localparam logic [OPC_W-1:0] OP_DEC = 5'd9;
  localparam logic [OPC_W-1:0] OP_FFT = 5'd10;
  localparam logic [OPC_W-1:0] OP_ENC = 5'd11;
  localparam logic [OPC_W-1:0] OP_DNC = 5'd12;
  localparam logic [OPC_W-1:0] OP_TNF = 5'd13;
  localparam logic [OPC_W-1:0] OP_STA = 5'd14;
  localparam logic [OPC_W-1:0] OP_HLT = 5'd15;

  // ALU strobe bit positions, same order as the opcodes
  localparam int unsigned CTRL_ADD = 0;
  localparam int unsigned CTRL_SUB = 1;
  localparam int unsigned CTRL_MUL = 2;
  localparam int unsigned CTRL_DIV = 3;
  localparam int unsigned CTRL_AND = 4;
  localparam int unsigned CTRL_OR  = 5;
  localparam int unsigned CTRL_XOR = 6;
  localparam int unsigned CTRL_NOT = 7;
  localparam int unsigned CTRL_INC = 8;
  localparam int unsigned CTRL_DEC = 9;
  localparam int unsigned CTRL_FFT = 10;
  localparam int unsigned CTRL_ENC = 11;
  localparam int unsigned CTRL_DNC = 12;
  localparam int unsigned CTRL_TNF = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_OPERAND,
    ST_EXEC,
    ST_STORE,
    ST_HALT
  } state_t;

  function automatic logic needs_dr(input logic [OPC_W-1:0] op);
    return (op <= OP_NOT) || (op == OP_TNF);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decode: instruction class flags and the one-hot ALU strobe.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  output logic              needs_dr_c,
  output logic              is_sta_c,
  output logic              is_hlt_c,
  output logic              is_illegal_c,
  output logic [CTRL_W-1:0] onehot_c
);

  always_comb begin
    needs_dr_c   = needs_dr(opcode);
    is_sta_c     = (opcode == OP_STA);
    is_hlt_c     = (opcode == OP_HLT);
    is_illegal_c = (opcode > OP_HLT);
    onehot_c     = '0;
    if (opcode <= OP_TNF) begin
      onehot_c = CTRL_W'(1) << opcode;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Fetch/decode/execute sequencer feeding a combinational ALU; owns AC, DR, IR, PC
// and the memory request port. Every output comes straight from a flop.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int unsigned         DATA_W = 19,
  parameter int unsigned         ADDR_W = 14,
  parameter logic [ADDR_W-1:0]   PC_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] dr,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  output logic              ovf_flag,
  output logic              illegal,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  state_t              state, state_d;
  logic [DATA_W-1:0]   ir, ir_d, ac_d, dr_d;
  logic [ADDR_W-1:0]   pc_d, mem_addr_d;
  logic [CTRL_W-1:0]   alu_ctrl_d;
  logic                ovf_flag_d, illegal_d, halted_d, mem_req_d, mem_we_d;
  logic                ack_ok;
  logic                needs_dr_c, is_sta_c, is_hlt_c, is_illegal_c;
  logic [CTRL_W-1:0]   onehot_c;

  alu_ctrl_decode u_decode (
    .opcode       (ir[DATA_W-1 -: OPC_W]),
    .needs_dr_c   (needs_dr_c),
    .is_sta_c     (is_sta_c),
    .is_hlt_c     (is_hlt_c),
    .is_illegal_c (is_illegal_c),
    .onehot_c     (onehot_c)
  );

  assign mem_wdata = ac;
  assign ack_ok    = mem_req & mem_ack;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= PC_RST;
      ir       <= '0;
      ac       <= '0;
      dr       <= '0;
      ovf_flag <= 1'b0;
      illegal  <= 1'b0;
      halted   <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= PC_RST;
      alu_ctrl <= '0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      ir       <= ir_d;
      ac       <= ac_d;
      dr       <= dr_d;
      ovf_flag <= ovf_flag_d;
      illegal  <= illegal_d;
      halted   <= halted_d;
      mem_req  <= mem_req_d;
      mem_we   <= mem_we_d;
      mem_addr <= mem_addr_d;
      alu_ctrl <= alu_ctrl_d;
    end
  end

  // Next state, datapath updates and next values of the registered outputs
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    ir_d       = ir;
    ac_d       = ac;
    dr_d       = dr;
    ovf_flag_d = ovf_flag;
    illegal_d  = illegal;

    unique case (state)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (ack_ok) begin
          ir_d    = mem_rdata;
          pc_d    = pc + ADDR_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_illegal_c) begin
          illegal_d = 1'b1;
          state_d   = ST_FETCH;
        end else if (is_hlt_c) begin
          state_d = ST_HALT;
        end else if (is_sta_c) begin
          state_d = ST_STORE;
        end else if (needs_dr_c) begin
          state_d = ST_OPERAND;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_OPERAND: begin
        if (ack_ok) begin
          dr_d    = mem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ac_d       = alu_result;
        ovf_flag_d = ovf_flag | alu_ovf;
        state_d    = ST_FETCH;
      end
      ST_STORE: begin
        if (ack_ok) state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An acked request always leaves one idle cycle before the next request
    mem_req_d  = ((state_d == ST_FETCH) || (state_d == ST_OPERAND) ||
                  (state_d == ST_STORE)) && !ack_ok;
    mem_we_d   = (state_d == ST_STORE) && !ack_ok;
    mem_addr_d = (state_d == ST_FETCH) ? pc_d : ir_d[ADDR_W-1:0];
    alu_ctrl_d = (state_d == ST_EXEC) ? onehot_c : '0;
    halted_d   = (state_d == ST_HALT);
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: behavioural memory with configurable
// wait states, a small ALU model, table-driven program run and corner sequences.
module tb_alu_ctrl_seq;

  localparam logic [13:0] PCR = 14'h3FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [13:0] mem_addr, pc;
  logic [18:0] mem_wdata, mem_rdata, ac, dr, alu_result;
  logic [13:0] alu_ctrl;
  logic        alu_ovf, ovf_flag, illegal, halted;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.DATA_W(19), .ADDR_W(14), .PC_RST(PCR)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ac(ac), .dr(dr), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_ovf(alu_ovf),
    .ovf_flag(ovf_flag), .illegal(illegal), .halted(halted), .pc(pc)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ALU stand-in
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_ctrl)
      14'h0001: begin
        alu_result = ac + dr;
        alu_ovf    = (ac[18] == dr[18]) && (alu_result[18] != ac[18]);
      end
      14'h0002: begin
        alu_result = ac - dr;
        alu_ovf    = (ac[18] != dr[18]) && (alu_result[18] != ac[18]);
      end
      14'h0004: alu_result = 19'(ac * dr);
      14'h0008: alu_result = (dr == '0) ? '0 : ac / dr;
      14'h0010: alu_result = ac & dr;
      14'h0020: alu_result = ac | dr;
      14'h0040: alu_result = ac ^ dr;
      14'h0080: alu_result = ~dr;
      14'h0100: alu_result = ac + 19'd1;
      14'h0200: alu_result = ac - 19'd1;
      14'h0400: alu_result = {ac[8:0], ac[18:9]};
      14'h0800: alu_result = ac << 1;
      14'h1000: alu_result = ac >> 1;
      14'h2000: alu_result = dr;
      default:  alu_result = '0;
    endcase
  end

  // Memory model and write scoreboard
  typedef struct { logic [13:0] a; logic [18:0] d; } wr_t;
  wr_t         wq[$];
  wr_t         we_exp;
  logic [18:0] mem [16384];
  int          lat = 0;
  int          wcnt = 0;
  int          run_len = 0;
  bit          last_acked = 1'b0;
  logic [13:0] held_addr = '0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0; wcnt = 0; run_len = 0; last_acked = 1'b0;
    end else begin
      if (last_acked) check("req_gap_after_ack", 32'(mem_req), 32'(0));
      last_acked = 1'b0;
      if (mem_req) begin
        if (run_len > 0) check("addr_stable", 32'(mem_addr), 32'(held_addr));
        held_addr = mem_addr;
        run_len++;
        if (mem_we) check("ctrl_in_store", 32'(alu_ctrl), 32'(0));
        if (wcnt >= lat) begin
          mem_ack = 1'b1; wcnt = 0; last_acked = 1'b1;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            check("wr_expected", 32'(wq.size() > 0), 32'(1));
            if (wq.size() > 0) begin
              we_exp = wq.pop_front();
              check("wr_addr", 32'(mem_addr), 32'(we_exp.a));
              check("wr_data", 32'(mem_wdata), 32'(we_exp.d));
            end
          end else begin
            mem_rdata = mem[mem_addr];
          end
        end else begin
          mem_ack = 1'b0; wcnt++;
        end
      end else begin
        if (run_len > 0) check("req_hold_len", 32'(run_len), 32'(lat + 1));
        run_len = 0; mem_ack = 1'b0; wcnt = 0;
      end
    end
  end

  function automatic logic [18:0] ins(input logic [4:0] op, input logic [13:0] a);
    return {op, a};
  endfunction

  task automatic clear_mem();
    foreach (mem[j]) mem[j] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; run = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ctrl(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < 200) begin
      @(negedge clk); cyc++;
      ok = (alu_ctrl != '0);
    end
  endtask

  task automatic wait_halt(output bit ok);
    int c = 0;
    while (!halted && c < 300) begin @(negedge clk); c++; end
    ok = halted;
  endtask

  typedef struct {
    logic [4:0] op; logic [18:0] opnd; logic [13:0] ctrl;
    logic [18:0] ac; logic [18:0] dr; int cyc;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  cyc, cnt;
    bit  ok;
    //           op    operand    strobe     ac         dr        cycles
    tbl[0]  = '{5'd0,  19'h5,     14'h0001, 19'h5,     19'h5,     4};
    tbl[1]  = '{5'd1,  19'h2,     14'h0002, 19'h3,     19'h2,     3};
    tbl[2]  = '{5'd2,  19'h7,     14'h0004, 19'h15,    19'h7,     3};
    tbl[3]  = '{5'd3,  19'h4,     14'h0008, 19'h5,     19'h4,     3};
    tbl[4]  = '{5'd5,  19'h30,    14'h0020, 19'h35,    19'h30,    3};
    tbl[5]  = '{5'd4,  19'h1C,    14'h0010, 19'h14,    19'h1C,    3};
    tbl[6]  = '{5'd6,  19'hFF,    14'h0040, 19'hEB,    19'hFF,    3};
    tbl[7]  = '{5'd8,  19'h0,     14'h0100, 19'hEC,    19'hFF,    2};
    tbl[8]  = '{5'd9,  19'h0,     14'h0200, 19'hEB,    19'hFF,    2};
    tbl[9]  = '{5'd11, 19'h0,     14'h0800, 19'h1D6,   19'hFF,    2};
    tbl[10] = '{5'd12, 19'h0,     14'h1000, 19'hEB,    19'hFF,    2};
    tbl[11] = '{5'd13, 19'h123,   14'h2000, 19'h123,   19'h123,   3};
    tbl[12] = '{5'd7,  19'h7FFF0, 14'h0080, 19'h0000F, 19'h7FFF0, 3};
    tbl[13] = '{5'd10, 19'h0,     14'h0400, 19'h3C00,  19'h7FFF0, 2};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_ac", 32'(ac), 32'(0));
    check("rst_dr", 32'(dr), 32'(0));
    check("rst_pc", 32'(pc), 32'(PCR));
    check("rst_req", 32'(mem_req), 32'(0));
    check("rst_ctrl", 32'(alu_ctrl), 32'(0));
    check("rst_flags", 32'({ovf_flag, illegal, halted, mem_we}), 32'(0));

    // Table-driven program starting at 0x3FFF (pc wraps after the first fetch)
    clear_mem();
    for (int k = 0; k < 14; k++) begin
      mem[14'(PCR + 14'(k))] = ins(tbl[k].op, 14'(14'h100 + 14'(k)));
      mem[14'(14'h100 + 14'(k))] = tbl[k].opnd;
    end
    mem[14'(PCR + 14'd14)] = ins(5'd14, 14'h200);
    mem[14'(PCR + 14'd15)] = ins(5'd20, 14'h0);
    mem[14'(PCR + 14'd16)] = ins(5'd15, 14'h0);
    wq.push_back('{a: 14'h200, d: 19'h3C00});
    lat = 0;
    run = 1'b1;
    for (int i = 0; i < 14; i++) begin
      wait_ctrl(cyc, ok);
      check("wait_ctrl", 32'(ok), 32'(1));
      if (i == 0) run = 1'b0;
      check($sformatf("lat_%0d", i), 32'(cyc), 32'(tbl[i].cyc));
      check($sformatf("ctrl_%0d", i), 32'(alu_ctrl), 32'(tbl[i].ctrl));
      @(negedge clk);
      check($sformatf("ctrl_off_%0d", i), 32'(alu_ctrl), 32'(0));
      check($sformatf("ac_%0d", i), 32'(ac), 32'(tbl[i].ac));
      check($sformatf("dr_%0d", i), 32'(dr), 32'(tbl[i].dr));
      check($sformatf("ovf_%0d", i), 32'(ovf_flag), 32'(0));
      check($sformatf("pc_%0d", i), 32'(pc), 32'(i));
    end
    wait_halt(ok);
    check("halt_reached", 32'(ok), 32'(1));
    check("illegal_set", 32'(illegal), 32'(1));
    check("ac_after_illegal", 32'(ac), 32'(19'h3C00));
    check("sta_mem", 32'(mem[14'h200]), 32'(19'h3C00));
    check("wq_drained", 32'(wq.size()), 32'(0));
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check("halt_no_req", 32'(cnt), 32'(0));
    check("halt_held", 32'(halted), 32'(1));

    // Sticky overflow
    do_reset();
    clear_mem();
    mem[14'h3FFF] = ins(5'd0, 14'h100);
    mem[14'h0000] = ins(5'd0, 14'h100);
    mem[14'h0001] = ins(5'd4, 14'h101);
    mem[14'h0002] = ins(5'd15, 14'h0);
    mem[14'h100]  = 19'h3FFFF;
    mem[14'h101]  = 19'h7FFFF;
    run = 1'b1;
    wait_ctrl(cyc, ok); @(negedge clk);
    check("ovf1_ac", 32'(ac), 32'(19'h3FFFF));
    check("ovf1_flag", 32'(ovf_flag), 32'(0));
    wait_ctrl(cyc, ok); @(negedge clk);
    check("ovf2_ac", 32'(ac), 32'(19'h7FFFE));
    check("ovf2_flag", 32'(ovf_flag), 32'(1));
    wait_ctrl(cyc, ok);
    check("ovf3_ctrl", 32'(alu_ctrl), 32'(14'h0010));
    @(negedge clk);
    check("ovf3_ac", 32'(ac), 32'(19'h7FFFE));
    check("ovf3_sticky", 32'(ovf_flag), 32'(1));
    wait_halt(ok);
    check("ovf_halt", 32'(ok), 32'(1));
    check("ovf_no_illegal", 32'(illegal), 32'(0));

    // Wait states: INC then STA 0x200 with two wait cycles per access
    do_reset();
    clear_mem();
    lat = 2;
    mem[14'h3FFF] = ins(5'd8, 14'h0);
    mem[14'h0000] = ins(5'd14, 14'h200);
    mem[14'h0001] = ins(5'd15, 14'h0);
    wq.push_back('{a: 14'h200, d: 19'h1});
    run = 1'b1;
    wait_ctrl(cyc, ok);
    check("ws_inc_lat", 32'(cyc), 32'(5));
    check("ws_inc_ctrl", 32'(alu_ctrl), 32'(14'h0100));
    @(negedge clk);
    check("ws_inc_ac", 32'(ac), 32'(1));
    wait_halt(ok);
    check("ws_halt", 32'(ok), 32'(1));
    check("ws_sta_mem", 32'(mem[14'h200]), 32'(1));
    check("ws_wq_drained", 32'(wq.size()), 32'(0));

    // Reset while the operand fetch is being acked
    do_reset();
    clear_mem();
    lat = 0;
    mem[14'h3FFF] = ins(5'd0, 14'h100);
    mem[14'h100]  = 19'h55;
    run = 1'b1;
    cnt = 0;
    ok  = 1'b0;
    while (!ok && cnt < 50) begin
      @(negedge clk); cnt++;
      ok = mem_req && !mem_we && (mem_addr == 14'h100);
    end
    check("rmid_found_operand", 32'(ok), 32'(1));
    #1 rst = 1'b1; run = 1'b0;
    @(negedge clk);
    check("rmid_dr", 32'(dr), 32'(0));
    check("rmid_req", 32'(mem_req), 32'(0));
    check("rmid_pc", 32'(pc), 32'(PCR));
    check("rmid_ac", 32'(ac), 32'(0));
    #1 rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check("rmid_idle_no_req", 32'(cnt), 32'(0));
    #1 run = 1'b1;
    @(negedge clk);
    check("rmid_restart_req", 32'(mem_req), 32'(1));
    check("rmid_restart_addr", 32'(mem_addr), 32'(PCR));
    wait_ctrl(cyc, ok);
    check("rmid_restart_ctrl", 32'(alu_ctrl), 32'(14'h0001));
    @(negedge clk);
    check("rmid_restart_ac", 32'(ac), 32'(19'h55));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
